// File: rtl/psma_tile_seq.sv
// Tile sequencer for the precision-scalable MAC array: config -> RUN (beats x sub-cycles) -> DRAIN.
// Optional stall counter output perf_stall is compiled in when PSMA_SEQ_PERF_EN is defined.
module psma_tile_seq #(
    parameter int REP_W   = 16,
    parameter int OUT_W   = 6,
    parameter int BG_TEMP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [3:0]       cfg_prec,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic [OUT_W-1:0] cfg_nouts,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [3:0]       mac_sub,
    output logic [OUT_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             cfg_err
`ifdef PSMA_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Last sub-cycle index: each 8b operand contributes 2 bit-groups, 4b one, 2b none.
    function automatic logic [3:0] sub_max_f(input logic [3:0] prec);
        logic [2:0] nz;
        logic [4:0] sub;
        nz  = 3'(!prec[3]) + 3'(!prec[2]) + 3'(!prec[1]) + 3'(!prec[0]);
        sub = 5'd1 << nz;
        return 4'(sub - 5'd1);
    endfunction

    state_t           state_r, state_nxt_s;
    logic [3:0]       prec_r;
    logic [REP_W-1:0] reps_r, rep_cnt_r;
    logic [OUT_W-1:0] nouts_r, out_sel_r;
    logic [3:0]       sub_cnt_r;
    logic             cfg_err_r;

    logic             idle_s, run_s, drain_s;
    logic             cfg_acc_s, cfg_rej_s;
    logic             in_ready_s, beat_acc_s, mac_en_s;
    logic [3:0]       sub_max_s;
    logic [REP_W-1:0] reps_m1_s;
    logic [OUT_W-1:0] nouts_m1_s;
    logic             sub_last_s, tile_done_s, drain_last_s, drain_hs_s;

    assign idle_s       = (state_r == ST_IDLE);
    assign run_s        = (state_r == ST_RUN);
    assign drain_s      = (state_r == ST_DRAIN);
    assign cfg_acc_s    = idle_s && cfg_valid && (cfg_reps != REP_W'(0));
    assign cfg_rej_s    = idle_s && cfg_valid && (cfg_reps == REP_W'(0));
    assign sub_max_s    = (BG_TEMP != 0) ? sub_max_f(prec_r) : 4'd0;
    assign reps_m1_s    = reps_r - REP_W'(1);
    assign nouts_m1_s   = nouts_r - OUT_W'(1);
    assign in_ready_s   = run_s && (sub_cnt_r == 4'd0);
    assign beat_acc_s   = in_ready_s && in_valid;
    // Once a beat is in, its remaining sub-cycles run regardless of in_valid.
    assign mac_en_s     = beat_acc_s || (run_s && (sub_cnt_r != 4'd0));
    assign sub_last_s   = mac_en_s && (sub_cnt_r == sub_max_s);
    assign tile_done_s  = sub_last_s && (rep_cnt_r == reps_m1_s);
    assign drain_last_s = (out_sel_r == nouts_m1_s);
    assign drain_hs_s   = drain_s && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and array/drain control outputs.
    always_comb begin
        state_nxt_s = state_r;
        cfg_ready   = 1'b0;
        busy        = 1'b1;
        in_ready    = 1'b0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        mac_sub     = 4'd0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_sel     = OUT_W'(0);
        case (state_r)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_acc_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                in_ready = in_ready_s;
                mac_en   = mac_en_s;
                mac_clr  = beat_acc_s && (rep_cnt_r == REP_W'(0));
                mac_sub  = sub_cnt_r;
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (tile_done_s) begin
                    state_nxt_s = (nouts_r != OUT_W'(0)) ? ST_DRAIN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_sel   = out_sel_r;
                out_last  = drain_last_s;
                if (abort || (out_ready && drain_last_s)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Config latch plus sub-cycle, repetition and drain-select counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prec_r    <= 4'd0;
            reps_r    <= REP_W'(0);
            nouts_r   <= OUT_W'(0);
            sub_cnt_r <= 4'd0;
            rep_cnt_r <= REP_W'(0);
            out_sel_r <= OUT_W'(0);
        end else if (cfg_acc_s) begin
            prec_r    <= cfg_prec;
            reps_r    <= cfg_reps;
            nouts_r   <= cfg_nouts;
            sub_cnt_r <= 4'd0;
            rep_cnt_r <= REP_W'(0);
            out_sel_r <= OUT_W'(0);
        end else if (idle_s || abort) begin
            sub_cnt_r <= 4'd0;
            rep_cnt_r <= REP_W'(0);
            out_sel_r <= OUT_W'(0);
        end else begin
            if (mac_en_s) begin
                if (sub_last_s) begin
                    sub_cnt_r <= 4'd0;
                    rep_cnt_r <= tile_done_s ? REP_W'(0) : rep_cnt_r + REP_W'(1);
                end else begin
                    sub_cnt_r <= sub_cnt_r + 4'd1;
                end
            end
            if (drain_hs_s) begin
                out_sel_r <= drain_last_s ? OUT_W'(0) : out_sel_r + OUT_W'(1);
            end
        end
    end

    // Rejected zero-repetition config pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_rej_s;
        end
    end

    assign cfg_err = cfg_err_r;

`ifdef PSMA_SEQ_PERF_EN
    logic [31:0] perf_stall_r;
    logic        stall_s;

    assign stall_s = (in_ready_s && !in_valid) || (drain_s && !out_ready);

    // Saturating stall counter, cleared when a tile starts and held in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_r <= 32'd0;
        end else if (cfg_acc_s) begin
            perf_stall_r <= 32'd0;
        end else if (stall_s && (perf_stall_r != 32'hFFFF_FFFF)) begin
            perf_stall_r <= perf_stall_r + 32'd1;
        end else begin
            perf_stall_r <= perf_stall_r;
        end
    end

    assign perf_stall = perf_stall_r;
`endif

endmodule
